// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: multi-cycle mult/div with HI/LO registers and pipeline stall.
// Optional madd (op 9) is compiled in when macro MDU_MADD_EN is defined.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  E_MD_Op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_Is_MD,
    output logic        E_MD_Busy,
    output logic        Stall_MD,
    output logic [31:0] E_MD_Out,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
`endif

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
    typedef enum logic [2:0] {
        K_MULT  = 3'd0,
        K_MULTU = 3'd1,
        K_DIV   = 3'd2,
        K_DIVU  = 3'd3,
        K_MADD  = 3'd4,
        K_NONE  = 3'd5
    } kind_t;

    state_t        state_r, state_s;
    kind_t         kind_r, kind_s;
    logic [3:0]    cnt_r, cnt_s;
    logic          busy_r, busy_s;
    logic          dz_r, dz_s;
    logic [31:0]   a_r, a_s;
    logic [31:0]   b_r, b_s;
    logic [31:0]   hi_r, hi_s;
    logic [31:0]   lo_r, lo_s;
    logic          start_s;
    logic signed [63:0] smul_s;
    logic [63:0]   umul_s;
    logic [63:0]   res_s;

    function automatic logic is_start_op(input logic [3:0] op);
        logic r;
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Returns {remainder, quotient}; the remainder keeps the dividend's sign.
    function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
            q = a;
            r = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {r, q};
    endfunction

    function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    assign start_s = (state_r == ST_IDLE) && is_start_op(E_MD_Op);
    assign smul_s  = $signed({{32{a_r[31]}}, a_r}) * $signed({{32{b_r[31]}}, b_r});
    assign umul_s  = {32'd0, a_r} * {32'd0, b_r};

    // Result selection from the latched operands, used on the final busy edge.
    always_comb begin
        res_s = {hi_r, lo_r};
        case (kind_r)
            K_MULT:  res_s = smul_s;
            K_MULTU: res_s = umul_s;
            K_DIV:   res_s = div_signed(a_r, b_r);
            K_DIVU:  res_s = div_unsigned(a_r, b_r);
`ifdef MDU_MADD_EN
            K_MADD:  res_s = {hi_r, lo_r} + smul_s;
`endif
            default: res_s = {hi_r, lo_r};
        endcase
    end

    // Next-state logic: start/latch in IDLE, count down and commit in BUSY.
    always_comb begin
        state_s = state_r;
        kind_s  = kind_r;
        cnt_s   = cnt_r;
        dz_s    = dz_r;
        a_s     = a_r;
        b_s     = b_r;
        hi_s    = hi_r;
        lo_s    = lo_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_s = ST_BUSY;
                    a_s     = E_A;
                    b_s     = E_B;
                    dz_s    = 1'b0;
                    case (E_MD_Op)
                        OP_MULT:  begin kind_s = K_MULT;  cnt_s = MULT_N; end
                        OP_MULTU: begin kind_s = K_MULTU; cnt_s = MULT_N; end
                        OP_DIV:   begin kind_s = K_DIV;   cnt_s = DIV_N; dz_s = (E_B == 32'd0); end
                        OP_DIVU:  begin kind_s = K_DIVU;  cnt_s = DIV_N; dz_s = (E_B == 32'd0); end
                        default:  begin kind_s = K_MADD;  cnt_s = MULT_N; end
                    endcase
                end else begin
                    case (E_MD_Op)
                        OP_MTHI: hi_s = E_A;
                        OP_MTLO: lo_s = E_A;
                        default: hi_s = hi_r;
                    endcase
                end
            end
            ST_BUSY: begin
                if (cnt_r <= 4'd1) begin
                    state_s = ST_IDLE;
                    cnt_s   = 4'd0;
                    if (!dz_r) begin
                        hi_s = res_s[63:32];
                        lo_s = res_s[31:0];
                    end else begin
                        hi_s = hi_r;
                        lo_s = lo_r;
                    end
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
        busy_s = (state_s == ST_BUSY);
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            kind_r  <= K_NONE;
            cnt_r   <= 4'd0;
            busy_r  <= 1'b0;
            dz_r    <= 1'b0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
        end else begin
            state_r <= state_s;
            kind_r  <= kind_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
            dz_r    <= dz_s;
            a_r     <= a_s;
            b_r     <= b_s;
            hi_r    <= hi_s;
            lo_r    <= lo_s;
        end
    end

    // Read port and stall request; both follow E/D inputs combinationally.
    always_comb begin
        case (E_MD_Op)
            OP_MFHI: E_MD_Out = hi_r;
            OP_MFLO: E_MD_Out = lo_r;
            default: E_MD_Out = 32'd0;
        endcase
        Stall_MD = D_Is_MD & (busy_r | start_s);
    end

    assign E_MD_Busy = busy_r;
    assign HI        = hi_r;
    assign LO        = lo_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: scoreboard of expected {HI,LO} per issued op.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  E_MD_Op;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        D_Is_MD;
    logic        E_MD_Busy;
    logic        Stall_MD;
    logic [31:0] E_MD_Out;
    logic [31:0] HI;
    logic [31:0] LO;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    hilo_t       sb_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    int          n_cmp = 0;
    int          n_bad = 0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset_n(reset_n), .E_MD_Op(E_MD_Op), .E_A(E_A), .E_B(E_B),
        .D_Is_MD(D_Is_MD), .E_MD_Busy(E_MD_Busy), .Stall_MD(Stall_MD),
        .E_MD_Out(E_MD_Out), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic hilo_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] hi, input logic [31:0] lo);
        hilo_t r;
        logic signed [63:0] sp;
        logic [63:0] up;
        r.hi = hi;
        r.lo = lo;
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        up = {32'd0, a} * {32'd0, b};
        case (op)
            4'd1: {r.hi, r.lo} = sp;
            4'd2: {r.hi, r.lo} = up;
            4'd3: if (b != 32'd0) begin r.lo = $signed(a) / $signed(b); r.hi = $signed(a) % $signed(b); end
            4'd4: if (b != 32'd0) begin r.lo = a / b; r.hi = a % b; end
            4'd7: r.hi = a;
            4'd8: r.lo = a;
`ifdef MDU_MADD_EN
            4'd9: {r.hi, r.lo} = {hi, lo} + sp;
`endif
            default: r.hi = hi;
        endcase
        return r;
    endfunction

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic d, input int exp_busy, input int exp_stall,
                          input int inj_at, input logic [3:0] inj_op, input logic [31:0] inj_a);
        hilo_t e;
        hilo_t g;
        int busy_n = 0;
        int stall_n = 0;
        @(negedge clk);
        E_MD_Op = op; E_A = a; E_B = b; D_Is_MD = d;
        e = model(op, a, b, m_hi, m_lo);
        m_hi = e.hi; m_lo = e.lo;
        sb_q.push_back(e);
        #1 if (Stall_MD) stall_n++;
        @(negedge clk);
        E_MD_Op = 4'd0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!E_MD_Busy) break;
            busy_n++;
            if (Stall_MD) stall_n++;
            if (busy_n == inj_at) begin
                E_MD_Op = inj_op; E_A = inj_a; E_B = inj_a;
            end else begin
                E_MD_Op = 4'd0;
            end
            @(negedge clk);
        end
        check({tag, "_busy"}, 64'(busy_n), 64'(exp_busy));
        check({tag, "_stall"}, 64'(stall_n), 64'(exp_stall));
        g = sb_q.pop_front();
        check({tag, "_hilo"}, {HI, LO}, g);
        D_Is_MD = 1'b0;
        E_MD_Op = 4'd0;
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rd;
        int          nb;

        reset_n = 1'b1; E_MD_Op = 4'd1; E_A = 32'd0; E_B = 32'd0; D_Is_MD = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("rst_busy", 64'(E_MD_Busy), 64'd0);
        check("rst_hilo", {HI, LO}, 64'd0);
        check("rst_stall", 64'(Stall_MD), 64'd1);
        E_MD_Op = 4'd5;
        #1 check("rst_mfhi", 64'(E_MD_Out), 64'd0);
        E_MD_Op = 4'd0; D_Is_MD = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // mult -1 * 2
        run_op("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 5, 0, 0, 4'd0, 32'd0);
        check("mult_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFE);

        // divu 7/2 with an MDU op waiting in D
        run_op("divu", 4'd4, 32'd7, 32'd2, 1'b1, 10, 11, 0, 4'd0, 32'd0);
        check("divu_const", {HI, LO}, {32'd1, 32'd3});
        @(negedge clk);
        E_MD_Op = 4'd6;
        #1 check("mflo", 64'(E_MD_Out), 64'd3);
        E_MD_Op = 4'd0;

        // divide by zero keeps HI/LO; an mthi during busy is dropped too
        run_op("mthi", 4'd7, 32'h1234, 32'd0, 1'b0, 0, 0, 0, 4'd0, 32'd0);
        run_op("mtlo", 4'd8, 32'h5678, 32'd0, 1'b0, 0, 0, 0, 4'd0, 32'd0);
        run_op("div0", 4'd3, 32'd99, 32'd0, 1'b0, 10, 0, 3, 4'd7, 32'h0000_AAAA);
        check("div0_const", {HI, LO}, {32'h1234, 32'h5678});

        // mult while busy is ignored: no relatch, no reload
        run_op("mult_ign", 4'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, 5, 0, 2, 4'd1, 32'd7);
        check("mult_ign_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFF1);

        // reset pulse on the 4th busy cycle of div
        @(negedge clk);
        E_MD_Op = 4'd3; E_A = 32'd100; E_B = 32'd7;
        @(negedge clk);
        E_MD_Op = 4'd0;
        repeat (3) @(negedge clk);
        #1 check("rstmid_busy_before", 64'(E_MD_Busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("rstmid_busy", 64'(E_MD_Busy), 64'd0);
        check("rstmid_hilo", {HI, LO}, 64'd0);
        #1 reset_n = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1 if (E_MD_Busy) nb++;
        end
        check("rstmid_nobusy", 64'(nb), 64'd0);
        check("rstmid_nowrite", {HI, LO}, 64'd0);

        // madd 3*4 onto {0,5}
        run_op("madd_hi", 4'd7, 32'd0, 32'd0, 1'b0, 0, 0, 0, 4'd0, 32'd0);
        run_op("madd_lo", 4'd8, 32'd5, 32'd0, 1'b0, 0, 0, 0, 4'd0, 32'd0);
`ifdef MDU_MADD_EN
        run_op("madd", 4'd9, 32'd3, 32'd4, 1'b1, 5, 6, 0, 4'd0, 32'd0);
        check("madd_const", {HI, LO}, {32'd0, 32'd17});
`else
        run_op("madd", 4'd9, 32'd3, 32'd4, 1'b1, 0, 0, 0, 4'd0, 32'd0);
        check("madd_const", {HI, LO}, {32'd0, 32'd5});
`endif

        // random mult/multu/div/divu against the model
        for (int i = 0; i < 8; i++) begin
            rop = 4'($urandom_range(1, 4));
            ra  = $urandom;
            rb  = $urandom;
            rd  = 1'(i % 2);
            if (rop >= 4'd3) begin
                rb = 32'($urandom_range(1, 5000));
                if ($urandom_range(0, 1) == 1) rb = -rb;
                if (ra == 32'h8000_0000) ra = 32'd1;
            end
            nb = (rop >= 4'd3) ? 10 : 5;
            run_op("rand", rop, ra, rb, rd, nb, rd ? nb + 1 : 0, 0, 4'd0, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy cycles for mult/multu (legal range 1..15).
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy cycles for div/divu (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port E_MD_Op  input  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd (only with REQ-024); all other codes are treated as none.
REQ-006 SHALL have port E_A  input  32  rs operand (forwarded value).
REQ-007 SHALL have port E_B  input  32  rt operand (forwarded value).
REQ-008 SHALL have port D_Is_MD  input  1  D-stage instruction is any MDU op.
REQ-009 SHALL have port E_MD_Busy  output  1  registered busy flag.
REQ-010 SHALL have port Stall_MD  output  1  stall request to the hazard unit (freeze F/D, bubble E).
REQ-011 SHALL have port E_MD_Out  output  32  mfhi/mflo read data.
REQ-012 SHALL have ports HI and LO  output  32 each  architectural registers.

Function
REQ-013 SHALL use two states: IDLE (busy=0) and BUSY (busy=1), held with a 4-bit down-counter cnt.
REQ-014 SHALL treat a start as E_MD_Op in {1,2,3,4,9} while in IDLE; at that edge it latches E_A and E_B, loads cnt with MULT_CYCLES (ops 1,2,9) or DIV_CYCLES (ops 3,4), and enters BUSY.
REQ-015 SHALL decrement cnt in BUSY on every edge; on the edge where cnt==1 it writes the result to HI/LO and returns to IDLE, so E_MD_Busy is high for exactly N cycles and HI/LO update on the Nth edge after start.
REQ-016 SHALL compute mult/madd as a 64-bit signed product and multu as unsigned, giving {HI,LO}; div/divu SHALL give LO=quotient and HI=remainder, signed (remainder takes the dividend's sign) or unsigned respectively.
REQ-017 SHALL leave HI/LO unchanged on divide by zero (E_B==0 at start), while still spending DIV_CYCLES in BUSY.
REQ-018 SHALL ignore any start op presented while in BUSY (no relatch, no counter reload).
REQ-019 SHALL write HI (mthi) or LO (mtlo) from E_A on the next edge only in IDLE; in BUSY these ops are ignored.
REQ-020 SHALL drive E_MD_Out combinationally: HI for op 5, LO for op 6, otherwise 0; during BUSY it returns the pre-operation value.
REQ-021 SHALL drive Stall_MD = D_Is_MD & (E_MD_Busy | start-op in E), so a D-stage MDU op stalls for the start cycle plus all N busy cycles and issues on the cycle after busy falls.

Reset
REQ-022 SHALL, while reset_n is low and regardless of clk, force HI=0, LO=0, cnt=0, state IDLE, E_MD_Busy=0 and latched operands to 0; an in-flight operation is discarded.
REQ-023 SHALL start normal operation on the first rising edge after reset_n goes high; Stall_MD and E_MD_Out follow the inputs combinationally during reset (with HI=LO=0).

Configuration
REQ-024 SHALL compile op 9 (madd: {HI,LO} <= {HI,LO} + signed(E_A*E_B), MULT_CYCLES latency) when macro MDU_MADD_EN is defined; without it, op 9 is treated as none (no start, no stall contribution, no write).

Verification
REQ-025 SHALL cover: reset, then mult with E_A=0xFFFFFFFF and E_B=2 -> E_MD_Busy high exactly 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFE.
REQ-026 SHALL cover: divu 7/2 with mflo in D -> Stall_MD high 11 cycles, then LO=3 and HI=1, and mflo reads 3.
REQ-027 SHALL cover: HI=0x1234 and LO=0x5678, then div with E_B=0 -> busy 10 cycles, then HI=0x1234 and LO=0x5678 unchanged.
REQ-028 SHALL cover: reset_n pulsed low on the 4th busy cycle of div -> E_MD_Busy=0 and HI=LO=0 immediately, with no later write.
REQ-029 SHALL cover: mult issued while in BUSY and mthi 0xAAAA issued in BUSY -> both ignored, and the first result is intact.
REQ-030 SHALL cover, with MDU_MADD_EN: HI=0 and LO=5, then madd 3*4 -> after 5 cycles LO=17 and HI=0; without the macro, same stimulus -> no busy and LO=5.
